clock_enable_gen: RTL
=====================

// Module: clock_enable_gen
//
// PURPOSE
//   Synthesizable, multi-channel clock-enable generator. It derives divided
//   periodic strobes and square waves from the single fabric clock.
//   Each channel has a runtime divisor, clean start/stop (no runt periods),
//   and a common phase-sync input.
//   Feeds CPU/video/IO timing logic as clock enables; no derived clocks are
//   used as real clocks.
//
// PARAMETERS
//   NUM_CH     2   number of independent channels
//   DIV_WIDTH  8   width of per-channel divisor / period counter
//
// PORTS
//   clock_i    in   1                  fabric clock; all logic on posedge
//   reset_i    in   1                  synchronous, active-high reset
//   enable_i   in   NUM_CH             per-channel run request (level)
//   div_i      in   NUM_CH*DIV_WIDTH   per-channel period in clocks; ch0 in LSBs
//   sync_i     in   1                  restart all RUN channels at phase 0
//   strobe_o   out  NUM_CH             1-cycle pulse at start of each period
//   clock_o    out  NUM_CH             divided square wave
//   running_o  out  NUM_CH             channel in RUN or DRAIN
//
// BEHAVIOUR
//   - One clock and one reset. Reset is synchronous and active-high, and it
//     overrides all other inputs, including mid-period.
//     On reset: every channel goes to IDLE, cnt=0, period=2;
//     strobe_o=0, clock_o=0, running_o=0.
//   - All outputs are registered. Per-channel state is {IDLE, RUN, DRAIN},
//     a DIV_WIDTH counter cnt, and a latched period N.
//   - Effective period: N = (div < 2) ? 2 : div. The value is latched only on
//     entry to RUN, on wrap (cnt==N-1), or on sync. A div_i change
//     mid-period never alters the current period.
//   - IDLE -> RUN when enable_i=1 at edge k. At edge k+1: cnt=0, strobe_o=1,
//     clock_o=1, running_o=1. Latency is 1 clock.
//   - RUN/DRAIN counting: cnt increments and wraps from N-1 to 0.
//     * strobe_o=1 exactly in the cycle where cnt==0.
//     * clock_o=1 while cnt < (N>>1), otherwise 0. For odd N, the high
//       phase is the shorter one.
//   - RUN -> DRAIN when enable_i=0. The channel keeps counting to cnt==N-1,
//     then goes to IDLE at the next edge with all outputs 0. This edge is
//     where a wrap would have occurred, so no period is ever truncated.
//   - DRAIN -> RUN if enable_i is reasserted before the wrap. Counting
//     continues without a gap or phase change.
//   - sync_i=1 at edge k: every channel in RUN gets cnt=0, reloads N, and
//     drives strobe_o=1 at edge k+1.
//     * IDLE and DRAIN channels ignore sync_i.
//     * Sync coincident with a wrap gives the same result as the wrap (one
//       strobe).
//     * Sync coincident with an IDLE->RUN start gives a normal start, already
//       aligned.
//   - Channels are fully independent apart from the shared sync_i.
//   - The counter never exceeds N-1. The maximum period is 2^DIV_WIDTH-1.
//
// TESTING
//   1. ch0 div=4, enable_i[0] rises at cycle 0.
//      -> strobe_o[0] at cycles 1,5,9,...; clock_o[0] pattern 1,1,0,0
//      repeating.
//   2. div=0, then div=1.
//      -> both behave as N=2: strobe every 2 cycles, clock_o alternates 1,0.
//   3. div 4->6 applied at cnt=1.
//      -> the current period completes in 4 cycles; the next strobe gap is 6.
//   4. div=5, enable dropped at cnt=1.
//      -> running_o stays 1 through cnt=4, all outputs 0 the next cycle, and
//      no extra strobe appears.
//      Repeat, reasserting enable at cnt=3 -> uninterrupted 5-cycle strobes.
//   5. ch0 div=3, ch1 div=5, both running; pulse sync_i.
//      -> both strobes fire in the same cycle, 1 clock after sync, then
//      resume gaps of 3 and 5.
//   6. reset_i pulsed mid-run with enable_i held high.
//      -> the cycle after reset, all outputs are 0.
//      -> the first strobe comes 1 clock after reset deasserts, followed by a
//      normal period.

Source files
------------

// File: rtl/clock_enable_gen_if.sv
// ---------------------------------------------------------------------------
// clock_enable_gen_if
//   Bundles the control inputs and the per-channel timing outputs of
//   clock_enable_gen. The clock and reset stay as plain module ports.
//
//   enable_i   [NUM_CH]            per-channel run request (level)
//   div_i      [NUM_CH*DIV_WIDTH]  per-channel period in clocks, ch0 in LSBs
//   sync_i     [1]                 restart all running channels at phase 0
//   strobe_o   [NUM_CH]            1-cycle pulse at the start of each period
//   clock_o    [NUM_CH]            divided square wave (used as an enable)
//   running_o  [NUM_CH]            channel is running or draining
//
//   master : the block that drives the controls (system / testbench)
//   slave  : the generator itself
// ---------------------------------------------------------------------------
interface clock_enable_gen_if #(
  parameter int NUM_CH    = 2,
  parameter int DIV_WIDTH = 8
);
  logic [NUM_CH-1:0]           enable_i;
  logic [NUM_CH*DIV_WIDTH-1:0] div_i;
  logic                        sync_i;
  logic [NUM_CH-1:0]           strobe_o;
  logic [NUM_CH-1:0]           clock_o;
  logic [NUM_CH-1:0]           running_o;

  modport master (
    output enable_i, div_i, sync_i,
    input  strobe_o, clock_o, running_o
  );

  modport slave (
    input  enable_i, div_i, sync_i,
    output strobe_o, clock_o, running_o
  );
endinterface

// File: rtl/clock_enable_gen.sv
// ---------------------------------------------------------------------------
// clock_enable_gen
//   Multi-channel clock-enable generator. Each channel produces a one-cycle
//   strobe at the start of every period and a divided square wave, with a
//   runtime period, glitch-free start/stop and a shared phase-sync input.
//   All outputs are registered; nothing here is meant to be used as a clock.
//
//   clock_i    in   fabric clock, all logic on posedge
//   reset_i    in   synchronous active-high reset, overrides everything
//   bus        slave modport of clock_enable_gen_if
//                (enable_i, div_i, sync_i in; strobe_o, clock_o, running_o out)
//
//   Channel life cycle: IDLE -> RUN on enable, RUN -> DRAIN when enable
//   drops, DRAIN finishes the current period and then returns to IDLE, or
//   goes back to RUN seamlessly if enable returns first.
// ---------------------------------------------------------------------------
module clock_enable_gen #(
  parameter int NUM_CH    = 2,
  parameter int DIV_WIDTH = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  clock_enable_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [DIV_WIDTH-1:0] MIN_PERIOD = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] ONE        = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] ZERO       = '0;

  logic [NUM_CH-1:0] w_strobe;
  logic [NUM_CH-1:0] w_clock;
  logic [NUM_CH-1:0] w_running;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t               r_state;
      logic [DIV_WIDTH-1:0] r_cnt;
      logic [DIV_WIDTH-1:0] r_period;
      logic                 r_strobe;
      logic                 r_clock;
      logic                 r_running;

      logic [DIV_WIDTH-1:0] w_div;
      logic [DIV_WIDTH-1:0] w_div_eff;
      logic                 w_at_wrap;
      logic                 w_en;
      state_t               w_state_next;
      logic [DIV_WIDTH-1:0] w_cnt_next;
      logic [DIV_WIDTH-1:0] w_period_next;

      assign w_div     = bus.div_i[gi*DIV_WIDTH +: DIV_WIDTH];
      // Periods below 2 cannot produce both a high and a low phase.
      assign w_div_eff = (w_div < MIN_PERIOD) ? MIN_PERIOD : w_div;
      assign w_at_wrap = (r_cnt == r_period - ONE);
      assign w_en      = bus.enable_i[gi];

      // Next-state / next-count decode. The period register only reloads
      // when a new period begins, so div_i changes never bend the current one.
      always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_period_next = r_period;
        case (r_state)
          ST_IDLE: begin
            if (w_en) begin
              w_state_next  = ST_RUN;
              w_cnt_next    = ZERO;
              w_period_next = w_div_eff;
            end
          end
          ST_RUN: begin
            if (w_en) begin
              // A sync landing on a wrap edge is indistinguishable from the wrap.
              if (bus.sync_i || w_at_wrap) begin
                w_cnt_next    = ZERO;
                w_period_next = w_div_eff;
              end else begin
                w_cnt_next = r_cnt + ONE;
              end
            end else if (w_at_wrap) begin
              // Enable dropped exactly at the period boundary: nothing is
              // left to finish, so stop here.
              w_state_next = ST_IDLE;
              w_cnt_next   = ZERO;
            end else begin
              // Channel is on its way out; sync no longer restarts it.
              w_state_next = ST_DRAIN;
              w_cnt_next   = r_cnt + ONE;
            end
          end
          ST_DRAIN: begin
            if (w_at_wrap) begin
              if (w_en) begin
                w_state_next  = ST_RUN;
                w_cnt_next    = ZERO;
                w_period_next = w_div_eff;
              end else begin
                w_state_next = ST_IDLE;
                w_cnt_next   = ZERO;
              end
            end else begin
              // Re-enable keeps the running count: no gap, no phase jump.
              w_state_next = w_en ? ST_RUN : ST_DRAIN;
              w_cnt_next   = r_cnt + ONE;
            end
          end
          default: begin
            w_state_next = ST_IDLE;
            w_cnt_next   = ZERO;
          end
        endcase
      end

      // Outputs are decoded from the next count so they line up with the
      // registered state (start strobe visible one clock after enable).
      always_ff @(posedge clock_i) begin
        if (reset_i) begin
          r_state   <= ST_IDLE;
          r_cnt     <= ZERO;
          r_period  <= MIN_PERIOD;
          r_strobe  <= 1'b0;
          r_clock   <= 1'b0;
          r_running <= 1'b0;
        end else begin
          r_state   <= w_state_next;
          r_cnt     <= w_cnt_next;
          r_period  <= w_period_next;
          r_running <= (w_state_next != ST_IDLE);
          r_strobe  <= (w_state_next != ST_IDLE) && (w_cnt_next == ZERO);
          // High phase is N>>1 clocks, so for odd N it is the shorter one.
          r_clock   <= (w_state_next != ST_IDLE) && (w_cnt_next < (w_period_next >> 1));
        end
      end

      assign w_strobe[gi]  = r_strobe;
      assign w_clock[gi]   = r_clock;
      assign w_running[gi] = r_running;
    end
  endgenerate

  assign bus.strobe_o  = w_strobe;
  assign bus.clock_o   = w_clock;
  assign bus.running_o = w_running;

endmodule
